// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared types and helpers for the systolic array blocks.
//   drain_state_t : drain FSM states (IDLE, STREAM)
//   idx_w()       : index width for a dimension of size n
//   elem_lsb()    : LSB of element (r,c) in a row-major flat vector of
//                   w-bit elements; with w = 1 it is the linear index
// ---------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/systolic_result_drain_rc_counter.sv
// ---------------------------------------------------------------------------
// rc_counter
// Row-major row/column wrap counter. The column advances on every enabled
// cycle. When it wraps, the row advances. When (ROWS-1, COLS-1) is passed,
// the counter wraps back to (0,0).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : advance one position
//   clr          : return to (0,0); has priority over en
//   row, col     : current position
//   last         : high at position (ROWS-1, COLS-1)
// ---------------------------------------------------------------------------
module rc_counter
  import systolic_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     clr,
  output logic [idx_w(ROWS)-1:0]   row,
  output logic [idx_w(COLS)-1:0]   col,
  output logic                     last
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  // The explicit wrap compares keep the sequence correct when ROWS or COLS
  // is not a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
// This block snapshots the NxN output-stationary PE results in a single cycle.
// It then pulses acc_clear so the array can start its next pass.
// The snapshot is streamed out row-major over a valid/ready interface.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : capture request; only honoured in IDLE
//   results_flat       : PE results, element (r,c) at [(r*N+c)*OUTWIDTH +: OUTWIDTH]
//   acc_clear          : one-cycle pulse after capture, clears PE accumulators
//   busy               : high while streaming
//   out_valid/out_ready: stream handshake
//   out_data           : current element, bit-exact copy of the snapshot
//   out_row/out_col    : position of out_data
//   out_last           : high with element (N-1,N-1)
//   done               : one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N        = 4,
  parameter int BITWIDTH = 4,
  parameter int OUTWIDTH = 2 * BITWIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [N*N*OUTWIDTH-1:0]      results_flat,
  output logic                         acc_clear,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUTWIDTH-1:0]          out_data,
  output logic [idx_w(N)-1:0]          out_row,
  output logic [idx_w(N)-1:0]          out_col,
  output logic                         out_last,
  output logic                         done
);

  localparam int IW = idx_w(N);

  drain_state_t        state, state_next;
  logic [OUTWIDTH-1:0] buffer [N][N];
  logic [IW-1:0]       row, col;
  logic                capture, beat, cnt_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (beat && cnt_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // out_data is a mux of registered state only. It therefore holds steady
  // under backpressure. It is gated to zero outside STREAM, so a stale
  // snapshot never shows on the bus.
  always_comb begin
    capture   = (state == IDLE) && start;
    out_valid = (state == STREAM);
    busy      = out_valid;
    beat      = out_valid && out_ready;
    out_last  = out_valid && cnt_last;
    out_row   = row;
    out_col   = col;
    out_data  = out_valid ? buffer[row][col] : '0;
  end

  // These are registered pulses. acc_clear lands in the first STREAM cycle.
  // done lands in the first IDLE cycle after the final beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
    end else begin
      acc_clear <= capture;
      done      <= beat && cnt_last;
    end
  end

  // The snapshot is written only on capture. This keeps it frozen for the
  // whole stream, even if the array starts producing new results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          buffer[r][c] <= '0;
    end else if (capture) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          buffer[r][c] <= results_flat[elem_lsb(r, c, N, OUTWIDTH) +: OUTWIDTH];
    end
  end

  // After the last beat the counter wraps itself back to (0,0).
  // Capture also forces it to (0,0), so a stream always starts there.
  rc_counter #(
    .ROWS (N),
    .COLS (N)
  ) u_rc_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (beat),
    .clr     (capture),
    .row     (row),
    .col     (col),
    .last    (cnt_last)
  );

endmodule

// File: tb/tb_systolic_result_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_result_drain
// Scoreboard bench for two drain instances: N=2 and N=4, both OUTWIDTH=8.
// A sel variable picks the instance under test; the other one never starts.
// On every accepted start, the monitor pushes the expected row-major
// sequence of the snapshot into a queue. On each falling edge it compares
// the presented element with the head of the queue, and pops the head on a
// beat. acc_clear and done are predicted from the same model events.
// ---------------------------------------------------------------------------
module tb_systolic_result_drain;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic out_ready;
  logic sel;
  logic [7:0] res [16];

  logic [2*2*W-1:0] res_a;
  logic [4*4*W-1:0] res_b;
  logic clr_a, busy_a, valid_a, last_a, done_a;
  logic clr_b, busy_b, valid_b, last_b, done_b;
  logic [7:0] data_a, data_b;
  logic [0:0] row_a, col_a;
  logic [1:0] row_b, col_b;

  logic m_clr, m_busy, m_valid, m_last, m_done;
  logic [7:0] m_data;
  logic [1:0] m_row, m_col;

  beat_t exp_q[$];
  logic  pend_done;
  logic  pend_clear;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    res_a = '0;
    res_b = '0;
    for (int i = 0; i < 4; i++)  res_a[i*W +: W] = res[i];
    for (int i = 0; i < 16; i++) res_b[i*W +: W] = res[i];
  end

  systolic_result_drain #(.N(2), .BITWIDTH(4), .OUTWIDTH(W)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start && !sel), .results_flat(res_a),
    .acc_clear(clr_a), .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_data(data_a), .out_row(row_a), .out_col(col_a), .out_last(last_a), .done(done_a)
  );

  systolic_result_drain #(.N(4), .BITWIDTH(4), .OUTWIDTH(W)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start && sel), .results_flat(res_b),
    .acc_clear(clr_b), .busy(busy_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_data(data_b), .out_row(row_b), .out_col(col_b), .out_last(last_b), .done(done_b)
  );

  // Present the selected instance on one set of monitor signals.
  always_comb begin
    if (sel) begin
      m_clr = clr_b; m_busy = busy_b; m_valid = valid_b; m_last = last_b; m_done = done_b;
      m_data = data_b; m_row = row_b; m_col = col_b;
    end else begin
      m_clr = clr_a; m_busy = busy_a; m_valid = valid_a; m_last = last_a; m_done = done_a;
      m_data = data_a; m_row = {1'b0, row_a}; m_col = {1'b0, col_a};
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model. A start is honoured only when no elements
  // of an earlier snapshot are outstanding.
  always @(negedge clk) begin : monitor
    logic busy_exp;
    int   nm;
    if (!reset_n) begin
      exp_q.delete();
      pend_done  = 1'b0;
      pend_clear = 1'b0;
    end else begin
      nm       = sel ? 4 : 2;
      busy_exp = (exp_q.size() > 0);
      check_output("out_valid", 32'(m_valid), 32'(busy_exp));
      check_output("busy", 32'(m_busy), 32'(busy_exp));
      check_output("done", 32'(m_done), 32'(pend_done));
      check_output("acc_clear", 32'(m_clr), 32'(pend_clear));
      pend_done  = 1'b0;
      pend_clear = 1'b0;
      if (busy_exp) begin
        check_output("out_data", 32'(m_data), 32'(exp_q[0].data));
        check_output("out_row", 32'(m_row), 32'(exp_q[0].row));
        check_output("out_col", 32'(m_col), 32'(exp_q[0].col));
        check_output("out_last", 32'(m_last), 32'(exp_q[0].last));
        if (out_ready) begin
          pend_done = exp_q[0].last;
          void'(exp_q.pop_front());
        end
      end
      if (start && !busy_exp) begin
        for (int r = 0; r < nm; r++)
          for (int c = 0; c < nm; c++)
            exp_q.push_back('{data: res[r*nm+c], row: 2'(r), col: 2'(c),
                              last: (r == nm-1) && (c == nm-1)});
        pend_clear = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d elements still pending after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, 32'(m_valid), 0);
    check_output({tag, "_busy"}, 32'(m_busy), 0);
    check_output({tag, "_last"}, 32'(m_last), 0);
    check_output({tag, "_clear"}, 32'(m_clr), 0);
    check_output({tag, "_done"}, 32'(m_done), 0);
    check_output({tag, "_data"}, 32'(m_data), 0);
    check_output({tag, "_row"}, 32'(m_row), 0);
    check_output({tag, "_col"}, 32'(m_col), 0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) res[i] = 8'h00;
    res[0] = 8'h11; res[1] = 8'h22; res[2] = 8'h33; res[3] = 8'h44;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    sel       = 1'b0;
    load_basic();
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    $display("[TB] basic drain N=2");
    apply_stimulus();
    wait_idle(50);

    $display("[TB] backpressure on 0x22");
    apply_stimulus();
    step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    wait_idle(50);

    $display("[TB] snapshot isolation");
    apply_stimulus();
    for (int i = 0; i < 16; i++) res[i] = 8'hFF;
    wait_idle(50);
    load_basic();

    $display("[TB] start during stream");
    apply_stimulus();
    step();
    apply_stimulus();
    wait_idle(50);

    $display("[TB] start in done cycle");
    apply_stimulus();
    repeat (4) step();
    apply_stimulus();
    wait_idle(50);

    $display("[TB] reset mid-stream");
    apply_stimulus();
    repeat (2) step();
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) step();
    reset_n = 1'b1;
    step();
    apply_stimulus();
    wait_idle(50);

    $display("[TB] N=4 all 0xFF");
    sel = 1'b1;
    for (int i = 0; i < 16; i++) res[i] = 8'hFF;
    step();
    apply_stimulus();
    wait_idle(100);

    $display("[TB] randomized streams");
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      step();
      for (int it = 0; it < 6; it++) begin
        int guard;
        for (int i = 0; i < 16; i++) res[i] = 8'($urandom);
        apply_stimulus();
        guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
          out_ready = ($urandom_range(0, 3) != 0);
          start     = ($urandom_range(0, 7) == 0);
          if ($urandom_range(0, 3) == 0) res[$urandom_range(0, 15)] = 8'($urandom);
          step();
          guard++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        wait_idle(100);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
